// File: rtl/uart_param.sv
// Parametrised full-duplex UART: independent TX and RX engines with configurable
// data width, parity mode, stop-bit count and baud divisor.
module uart_param #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT * 2);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic             PAR_EN    = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
  } rx_state_t;

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  rx_state_t            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 rx_perr;
  logic                 rx_ferr;

  // TX engine: the idx counter is reused to count stop bits
  always_ff @(posedge clk) begin
    if (areset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ PAR_ODD;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_out   <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_DATA) begin
              tx_idx <= '0;
              if (PAR_EN) begin
                tx_out   <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_out   <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + IDX_W'(1);
              tx_out   <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_out   <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_STOP) begin
              tx_idx   <= '0;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_idx <= tx_idx + IDX_W'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX engine: synchronised line, start verified at mid-bit, all samples at bit centres
  always_ff @(posedge clk) begin
    if (areset) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      rx_perr       <= 1'b0;
      rx_ferr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_meta  <= rx_in;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_busy  <= 1'b1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_busy  <= 1'b0;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == LAST_DATA) begin
              rx_idx   <= '0;
              rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_perr  <= rx_sync ^ (^rx_shift) ^ PAR_ODD;
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (!rx_sync) rx_ferr <= 1'b1;
            if (rx_idx == LAST_STOP) begin
              rx_idx        <= '0;
              rx_valid      <= 1'b1;
              rx_data       <= rx_shift;
              rx_parity_err <= rx_perr;
              rx_frame_err  <= rx_ferr | ~rx_sync;
              rx_busy       <= 1'b0;
              // a low line here is a break: wait for it to return high before re-arming
              rx_state      <= rx_sync ? RX_IDLE : RX_WAIT_IDLE;
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: an 8N1 and a 7E2 instance at 16 clocks/bit,
// checked every cycle against a frame-level model plus literal expectations.
`timescale 1ns/1ps
module tb_uart_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset;
  logic       tx_start_a, tx_start_b;
  logic [7:0] txd_a;
  logic [6:0] txd_b;
  logic       rx_drv_a, rx_drv_b;
  logic       loop_a;
  wire        rx_line_a;
  wire  [1:0] tx_out_w, tx_busy_w, tx_done_w, rx_valid_w, pe_w, fe_w, rxb_w;
  wire  [7:0] rxd_a;
  wire  [6:0] rxd_b;

  assign rx_line_a = loop_a ? tx_out_w[0] : rx_drv_a;

  uart_param #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .areset(areset), .tx_start(tx_start_a), .tx_data(txd_a),
    .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0]), .tx_out(tx_out_w[0]),
    .rx_in(rx_line_a), .rx_data(rxd_a), .rx_valid(rx_valid_w[0]),
    .rx_parity_err(pe_w[0]), .rx_frame_err(fe_w[0]), .rx_busy(rxb_w[0]));

  uart_param #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .areset(areset), .tx_start(tx_start_b), .tx_data(txd_b),
    .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1]), .tx_out(tx_out_w[1]),
    .rx_in(rx_drv_b), .rx_data(rxd_b), .rx_valid(rx_valid_w[1]),
    .rx_parity_err(pe_w[1]), .rx_frame_err(fe_w[1]), .rx_busy(rxb_w[1]));

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         lo;
    int         hi;
  } exp_t;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  logic        m_busy [2];
  logic        m_done [2];
  int          m_t    [2];
  int          m_n    [2];
  logic [15:0] m_bits [2];
  logic [8:0]  last_d [2];
  logic        last_pe[2];
  logic        last_fe[2];
  int          nvalid [2];
  int          vcyc   [2];
  int          last_fall[2];
  exp_t        sb_a[$];
  exp_t        sb_b[$];

  function automatic int nd(input int w); return (w == 0) ? 8 : 7; endfunction
  function automatic int pm(input int w); return (w == 0) ? 0 : 2; endfunction
  function automatic int ns(input int w); return (w == 0) ? 1 : 2; endfunction
  function automatic int lat(input int w);
    return HALF + CPB * (nd(w) + ((pm(w) != 0) ? 1 : 0) + ns(w));
  endfunction

  function automatic void chk(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s u%0d cyc=%0d got=%0h want=%0h", name, w, cyc, act, exp);
  endfunction

  function automatic logic par(input int w, input logic [8:0] d);
    logic x = 1'b0;
    for (int i = 0; i < nd(w); i++) x ^= d[i];
    return (pm(w) == 1) ? ~x : x;
  endfunction

  // line bits of a frame, index 0 = start bit
  function automatic logic [15:0] frame_bits(input int w, input logic [8:0] d, output int n);
    logic [15:0] b = '0;
    int k = 1;
    for (int i = 0; i < nd(w); i++) begin b[k] = d[i]; k++; end
    if (pm(w) != 0) begin b[k] = par(w, d); k++; end
    for (int i = 0; i < ns(w); i++) begin b[k] = 1'b1; k++; end
    n = k;
    return b;
  endfunction

  function automatic void push(input int w, input exp_t e);
    if (w == 0) sb_a.push_back(e);
    else sb_b.push_back(e);
  endfunction

  function automatic void set_rx(input int w, input logic v);
    if (w == 0) rx_drv_a = v;
    else rx_drv_b = v;
  endfunction

  // advance the model by one clock edge and compare every output
  task automatic step(input int w);
    logic [8:0] d, act_d;
    logic       start, exp_out;
    int         n;
    exp_t       e;
    d     = (w == 0) ? {1'b0, txd_a} : {2'b0, txd_b};
    start = (w == 0) ? tx_start_a : tx_start_b;
    if (areset) begin
      m_busy[w] = 1'b0; m_done[w] = 1'b0; m_t[w] = 0;
      last_d[w] = '0; last_pe[w] = 1'b0; last_fe[w] = 1'b0;
      if (w == 0) sb_a.delete(); else sb_b.delete();
    end else begin
      m_done[w] = 1'b0;
      if (!m_busy[w] && start) begin
        m_bits[w] = frame_bits(w, d, n);
        m_n[w] = n; m_busy[w] = 1'b1; m_t[w] = 0;
        if (w == 0 && loop_a) begin
          e.d = d; e.pe = 1'b0; e.fe = 1'b0; e.lo = cyc + lat(w) + 2; e.hi = cyc + lat(w) + 3;
          push(w, e);
        end
      end else if (m_busy[w]) begin
        m_t[w]++;
        if (m_t[w] == m_n[w] * CPB) begin m_busy[w] = 1'b0; m_done[w] = 1'b1; end
      end
    end
    exp_out = m_busy[w] ? m_bits[w][m_t[w] / CPB] : 1'b1;
    chk("tx_out", w, 32'(tx_out_w[w]), 32'(exp_out));
    chk("tx_busy", w, 32'(tx_busy_w[w]), 32'(m_busy[w]));
    chk("tx_done", w, 32'(tx_done_w[w]), 32'(m_done[w]));

    act_d = (w == 0) ? {1'b0, rxd_a} : {2'b0, rxd_b};
    if (rx_valid_w[w]) begin
      nvalid[w]++;
      vcyc[w] = cyc;
      if ((w == 0 && sb_a.size() == 0) || (w == 1 && sb_b.size() == 0)) begin
        chk("rx_unexpected_valid", w, 32'(1), 32'(0));
      end else begin
        e = (w == 0) ? sb_a.pop_front() : sb_b.pop_front();
        chk("rx_data", w, 32'(act_d), 32'(e.d));
        chk("rx_parity_err", w, 32'(pe_w[w]), 32'(e.pe));
        chk("rx_frame_err", w, 32'(fe_w[w]), 32'(e.fe));
        chk("rx_latency", w, 32'(cyc >= e.lo && cyc <= e.hi), 32'(1));
        last_d[w] = e.d; last_pe[w] = e.pe; last_fe[w] = e.fe;
      end
    end else begin
      chk("rx_data_hold", w, 32'(act_d), 32'(last_d[w]));
      chk("rx_perr_hold", w, 32'(pe_w[w]), 32'(last_pe[w]));
      chk("rx_ferr_hold", w, 32'(fe_w[w]), 32'(last_fe[w]));
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      m_busy[w] = 1'b0; m_done[w] = 1'b0; m_t[w] = 0; m_n[w] = 0; m_bits[w] = '0;
      last_d[w] = '0; last_pe[w] = 1'b0; last_fe[w] = 1'b0; nvalid[w] = 0; vcyc[w] = 0; last_fall[w] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int w = 0; w < 2; w++) step(w);
    end
  end

  task automatic send_rx(input int w, input logic [8:0] d, input logic flip, input logic [1:0] stops);
    logic [15:0] b;
    int          n;
    logic        fe;
    exp_t        e;
    b = frame_bits(w, d, n);
    if (pm(w) != 0) b[nd(w) + 1] = b[nd(w) + 1] ^ flip;
    fe = 1'b0;
    for (int i = 0; i < ns(w); i++) begin
      b[n - ns(w) + i] = stops[i];
      if (!stops[i]) fe = 1'b1;
    end
    @(negedge clk);
    e.d = d; e.pe = flip; e.fe = fe; e.lo = cyc + lat(w) + 2; e.hi = cyc + lat(w) + 3;
    last_fall[w] = cyc;
    push(w, e);
    for (int i = 0; i < n; i++) begin
      set_rx(w, b[i]);
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int w);
    int t = 0;
    while (!tx_done_w[w] && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) chk("tx_done_timeout", w, 32'(0), 32'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, base;
    logic [9:0] pat;
    areset = 1'b1; tx_start_a = 1'b0; tx_start_b = 1'b0; txd_a = '0; txd_b = '0;
    rx_drv_a = 1'b1; rx_drv_b = 1'b1; loop_a = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_tx_out", w, 32'(tx_out_w[w]), 32'(1));
      chk("rst_tx_busy", w, 32'(tx_busy_w[w]), 32'(0));
      chk("rst_rx_busy", w, 32'(rxb_w[w]), 32'(0));
    end
    chk("rst_rx_data", 0, 32'(rxd_a), 32'(0));
    areset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 receive of 0x5A with literal latency window
    send_rx(0, 9'h05A, 1'b0, 2'b11);
    repeat (CPB) @(negedge clk);
    chk("rx_5a_data_lit", 0, 32'(rxd_a), 32'h5A);
    chk("rx_5a_ferr_lit", 0, 32'(fe_w[0]), 32'(0));
    chk("rx_5a_lat_lit", 0, 32'(vcyc[0] - last_fall[0] >= 154 && vcyc[0] - last_fall[0] <= 155), 32'(1));

    // 8N1 transmit of 0xA5, a mid-frame tx_start with new data must be ignored
    pat = 10'b1101001010;
    @(negedge clk); txd_a = 8'hA5; tx_start_a = 1'b1;
    @(negedge clk); tx_start_a = 1'b0; k = cyc;
    for (int i = 0; i < 10; i++) begin
      while (cyc < k + i * CPB + HALF) @(negedge clk);
      chk("tx_a5_bit_lit", i, 32'(tx_out_w[0]), 32'(pat[i]));
      if (i == 4) begin
        txd_a = 8'hFF; tx_start_a = 1'b1;
        @(negedge clk); tx_start_a = 1'b0;
      end
    end
    wait_done(0);
    chk("tx_done_time_lit", 0, 32'(cyc - k), 32'(160));
    repeat (CPB) @(negedge clk);

    // false start: a short low glitch releases rx_busy after half a bit
    @(negedge clk); rx_drv_a = 1'b0;
    repeat (6) @(negedge clk); rx_drv_a = 1'b1;
    chk("glitch_busy_set", 0, 32'(rxb_w[0]), 32'(1));
    repeat (6) @(negedge clk);
    chk("glitch_busy_clear", 0, 32'(rxb_w[0]), 32'(0));
    repeat (2 * CPB) @(negedge clk);

    // reset in the middle of a TX frame and an RX frame
    @(negedge clk); txd_a = 8'h5A; tx_start_a = 1'b1; rx_drv_a = 1'b0;
    @(negedge clk); tx_start_a = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("pre_rst_tx_busy", 0, 32'(tx_busy_w[0]), 32'(1));
    chk("pre_rst_rx_busy", 0, 32'(rxb_w[0]), 32'(1));
    areset = 1'b1; rx_drv_a = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_tx_out", 0, 32'(tx_out_w[0]), 32'(1));
    chk("mid_rst_tx_busy", 0, 32'(tx_busy_w[0]), 32'(0));
    chk("mid_rst_rx_busy", 0, 32'(rxb_w[0]), 32'(0));
    @(negedge clk); areset = 1'b0;
    repeat (12 * CPB) @(negedge clk);

    // loopback, three frames back to back
    loop_a = 1'b1;
    base = nvalid[0];
    @(negedge clk); txd_a = 8'h00; tx_start_a = 1'b1;
    @(negedge clk); tx_start_a = 1'b0;
    wait_done(0); txd_a = 8'hFF; tx_start_a = 1'b1;
    @(negedge clk); tx_start_a = 1'b0;
    wait_done(0); txd_a = 8'h5A; tx_start_a = 1'b1;
    @(negedge clk); tx_start_a = 1'b0;
    wait_done(0);
    repeat (CPB) @(negedge clk);
    chk("loop_valid_count", 0, 32'(nvalid[0] - base), 32'(3));
    chk("loop_last_lit", 0, 32'(rxd_a), 32'h5A);
    loop_a = 1'b0;

    // 7E2: good parity, then flipped parity bit
    send_rx(1, 9'h041, 1'b0, 2'b11);
    repeat (CPB) @(negedge clk);
    chk("rx_41_perr_lit", 1, 32'(pe_w[1]), 32'(0));
    send_rx(1, 9'h041, 1'b1, 2'b11);
    repeat (CPB) @(negedge clk);
    chk("rx_41_bad_perr_lit", 1, 32'(pe_w[1]), 32'(1));
    chk("rx_41_bad_data_lit", 1, 32'(rxd_b), 32'h41);

    // 7E2 transmit of 0x41 while a frame is being received
    fork
      send_rx(1, 9'h055, 1'b0, 2'b11);
      begin
        @(negedge clk); txd_b = 7'h41; tx_start_b = 1'b1;
        @(negedge clk); tx_start_b = 1'b0; k = cyc;
        while (cyc < k + 8 * CPB + HALF) @(negedge clk);
        chk("tx_41_parity_lit", 1, 32'(tx_out_w[1]), 32'(0));
        wait_done(1);
      end
    join
    repeat (CPB) @(negedge clk);

    // second stop bit low, line held low (break), then a clean frame
    send_rx(1, 9'h03C, 1'b0, 2'b01);
    chk("rx_3c_ferr_lit", 1, 32'(fe_w[1]), 32'(1));
    chk("rx_3c_data_lit", 1, 32'(rxd_b), 32'h3C);
    repeat (3 * CPB) @(negedge clk);
    rx_drv_b = 1'b1;
    repeat (CPB) @(negedge clk);
    base = nvalid[1];
    send_rx(1, 9'h011, 1'b0, 2'b11);
    repeat (CPB) @(negedge clk);
    chk("break_one_valid", 1, 32'(nvalid[1] - base), 32'(1));
    chk("rx_11_data_lit", 1, 32'(rxd_b), 32'h11);
    chk("rx_11_ferr_lit", 1, 32'(fe_w[1]), 32'(0));
    chk("rx_11_perr_lit", 1, 32'(pe_w[1]), 32'(0));

    repeat (2 * CPB) @(negedge clk);
    chk("sb_empty", 0, 32'(sb_a.size()), 32'(0));
    chk("sb_empty", 1, 32'(sb_b.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
